clk_div_prog: RTL

Multi-channel, runtime-programmable clock divider producing, per channel, a ~50% duty divided clock and a one-cycle tick strobe. Sits between the board clock and the CPU step clock and 60 Hz timer/sound tick consumers. Divisors are reloaded by a write port and take effect glitch-free at the channel's next period boundary.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 93 +++++++++
 rtl/clk_div_prog.sv | 44 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: channel-index width and
// divisor clamping.
package clk_div_pkg;

  localparam int unsigned MaxWidth = 32;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero divisor would never wrap, so it is treated as divide-by-one.
  function automatic logic [MaxWidth-1:0] clamp_div(input logic [MaxWidth-1:0] d);
    return (d == '0) ? MaxWidth'(1) : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow divisor, phase counter, registered
// divided clock and period-start tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic             DefClk = (DEFAULT_DIV >= 2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shd_q, shd_d;
  logic             pnd_q, pnd_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    wrap   = (cnt_q == (div_q - One));
    cnt_d  = cnt_q;
    div_d  = div_q;
    shd_d  = shd_q;
    pnd_d  = pnd_q;
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d  = '0;
      tick_d = en_i;
      if (pnd_q) begin
        div_d = shd_q;
        pnd_d = 1'b0;
      end
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pnd_q) begin
          div_d = shd_q;
          pnd_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + One;
      end
    end else if (pnd_q) begin
      // Nothing in progress while disabled, so a pending divisor applies at once.
      div_d = shd_q;
      pnd_d = 1'b0;
      cnt_d = '0;
    end
    // A write on an apply edge re-arms pending and waits for the next boundary.
    if (wr_i) begin
      shd_d = WIDTH'(clamp_div(MaxWidth'(wr_div_i)));
      pnd_d = 1'b1;
    end
    clk_d = en_i ? (cnt_d < (div_d >> 1)) : clk_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= DefDiv;
      shd_q  <= DefDiv;
      pnd_q  <= 1'b0;
      clk_q  <= DefClk;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pnd_q  <= pnd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pnd_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider; decodes the divisor write
// port into per-channel strobes and broadcasts restart.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned ChW        = ch_idx_w(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                restart_i,
  input  logic                wr_en_i,
  input  logic [ChW-1:0]      wr_ch_i,
  input  logic [WIDTH-1:0]    wr_div_i,
  output logic [CHANNELS-1:0] clk_out_o,
  output logic [CHANNELS-1:0] tick_o,
  output logic [CHANNELS-1:0] pending_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // Out-of-range channel indices match no channel and are dropped.
    logic wr_sel;
    assign wr_sel = wr_en_i && (wr_ch_i == ChW'(c));

    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .rst       (rst),
      .en_i      (en_i[c]),
      .restart_i (restart_i),
      .wr_i      (wr_sel),
      .wr_div_i  (wr_div_i),
      .clk_out_o (clk_out_o[c]),
      .tick_o    (tick_o[c]),
      .pending_o (pending_o[c])
    );
  end

endmodule
